// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front-end stream blocks: FSM states and
// the beat-counter sizing helper.
package fir_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // Counter width for a given beat count; never narrower than one bit.
    function automatic int cnt_width(input int beats);
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry valid/ready output register. Reports "free" when it is empty
// or is being drained this cycle, so a new word may load without a bubble.
module stream_hold_reg #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] iv_data,
    input  logic         i_ready,
    output logic [W-1:0] ov_data,
    output logic         o_valid,
    output logic         o_free
);

    logic w_consume;

    assign w_consume = o_valid && i_ready && i_en;
    assign o_free    = !o_valid || w_consume;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_data <= '0;
            o_valid <= 1'b0;
        end else if (i_en) begin
            if (i_load) begin
                ov_data <= iv_data;
                o_valid <= 1'b1;
            end else if (w_consume) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/deserializer_stream.sv
// Serial-to-parallel converter: packs LANES-bit beats into WORD_W-bit words
// and hands them to the FIR input through a single-entry holding register.
module deserializer_stream
    import fir_pkg::*;
#(
    parameter int WORD_W    = 24,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [LANES-1:0]  iv_din,
    input  logic              i_din_valid,
    output logic              o_din_ready,
    output logic [WORD_W-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_partial
);

    localparam int BEATS = WORD_W / LANES;
    localparam int CNT_W = cnt_width(BEATS);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [WORD_W-1:0] FIELD_MASK = WORD_W'((1 << LANES) - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_shift;

    logic [CNT_W-1:0]  w_pos;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_load_data;
    logic              w_accept;
    logic              w_last;
    logic              w_free;
    logic              w_load;
    int                w_shamt;

    assign o_din_ready = !i_rst && i_en && (r_state == ST_COLLECT);
    assign w_accept    = i_din_valid && o_din_ready;
    assign w_last      = (r_cnt == LAST_CNT);
    assign w_pos       = (MSB_FIRST != 0) ? (LAST_CNT - r_cnt) : r_cnt;
    assign o_partial   = (r_state == ST_HOLD) || (r_cnt != '0);

    // Current shift contents with this cycle's beat dropped into its field.
    always_comb begin
        w_shamt = int'(w_pos) * LANES;
        w_word  = (r_shift & ~(FIELD_MASK << w_shamt))
                | (WORD_W'(iv_din) << w_shamt);
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_data = w_word;
        if (!i_rst && i_en && !i_clr && w_free) begin
            if (r_state == ST_COLLECT) begin
                w_load = w_accept && w_last;
            end else begin
                w_load      = 1'b1;
                w_load_data = r_shift;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_COLLECT;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_en) begin
            case (r_state)
                ST_COLLECT: begin
                    if (i_clr) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (w_free) begin
                                r_shift <= '0;
                            end else begin
                                r_shift <= w_word;
                                r_state <= ST_HOLD;
                            end
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_shift <= w_word;
                        end
                    end
                end
                ST_HOLD: begin
                    // Either a clear or a drained output frees the shift register.
                    if (i_clr || w_free) begin
                        r_shift <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    stream_hold_reg #(
        .W(WORD_W)
    ) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_load  (w_load),
        .iv_data (w_load_data),
        .i_ready (i_dout_ready),
        .ov_data (ov_dout),
        .o_valid (o_dout_valid),
        .o_free  (w_free)
    );

endmodule

// File: tb/tb_deserializer_stream.sv
// Directed bench for deserializer_stream: 24x1 LSB-first instance plus 16x4
// MSB-first / LSB-first instances fed the same beats.
module tb_deserializer_stream;

    logic clk = 1'b0;
    logic rst, en, clr;

    logic [0:0]  a_din;
    logic        a_dv, a_dr, a_dov, a_drdy, a_part;
    logic [23:0] a_dout;

    logic [3:0]  bc_din;
    logic        bc_dv, bc_drdy;
    logic        b_dr, b_dov, b_part;
    logic        c_dr, c_dov, c_part;
    logic [15:0] b_dout, c_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deserializer_stream #(.WORD_W(24), .LANES(1), .MSB_FIRST(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .iv_din(a_din), .i_din_valid(a_dv), .o_din_ready(a_dr),
        .ov_dout(a_dout), .o_dout_valid(a_dov), .i_dout_ready(a_drdy),
        .o_partial(a_part)
    );

    deserializer_stream #(.WORD_W(16), .LANES(4), .MSB_FIRST(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .iv_din(bc_din), .i_din_valid(bc_dv), .o_din_ready(b_dr),
        .ov_dout(b_dout), .o_dout_valid(b_dov), .i_dout_ready(bc_drdy),
        .o_partial(b_part)
    );

    deserializer_stream #(.WORD_W(16), .LANES(4), .MSB_FIRST(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .iv_din(bc_din), .i_din_valid(bc_dv), .o_din_ready(c_dr),
        .ov_dout(c_dout), .o_dout_valid(c_dov), .i_dout_ready(bc_drdy),
        .o_partial(c_part)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends beats 0..n-1 of w on the 24x1 instance, one per cycle.
    task automatic send_a(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            a_dv  = 1'b1;
            a_din = w[i];
            step();
        end
        a_dv = 1'b0;
    endtask

    logic [23:0] w1, w2;
    logic [3:0]  nib [4];

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        a_din = '0; a_dv = 1'b0; a_drdy = 1'b0;
        bc_din = '0; bc_dv = 1'b0; bc_drdy = 1'b0;

        // Reset
        step();
        step();
        chk("ready_in_reset", a_dr, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_dout_valid", a_dov, 1'b0);
        chk("reset_dout", a_dout, 24'h0);
        chk("reset_partial", a_part, 1'b0);
        chk("ready_after_reset", a_dr, 1'b1);
        chk("reset_b_dout", b_dout, 16'h0);

        // 24x1 LSB-first, sink ready: one-cycle latency after 24th beat
        a_drdy = 1'b1;
        w1 = 24'hA5C396;
        for (int i = 0; i < 24; i++) begin
            a_dv  = 1'b1;
            a_din = w1[i];
            step();
            if (i == 5)  chk("partial_mid_word", a_part, 1'b1);
            if (i == 22) chk("valid_before_last", a_dov, 1'b0);
        end
        a_dv = 1'b0;
        chk("lsb_word_valid", a_dov, 1'b1);
        chk("lsb_word", a_dout, 24'hA5C396);
        chk("partial_after_word", a_part, 1'b0);
        step();
        chk("lsb_word_consumed", a_dov, 1'b0);

        // 16x4 MSB-first and LSB-first with beats 1,2,3,4
        bc_drdy = 1'b1;
        nib[0] = 4'h1; nib[1] = 4'h2; nib[2] = 4'h3; nib[3] = 4'h4;
        for (int i = 0; i < 4; i++) begin
            bc_dv  = 1'b1;
            bc_din = nib[i];
            step();
        end
        bc_dv = 1'b0;
        chk("msb_first_valid", b_dov, 1'b1);
        chk("msb_first_word", b_dout, 16'h1234);
        chk("lsb_first_valid", c_dov, 1'b1);
        chk("lsb_first_word", c_dout, 16'h4321);
        step();

        // Backpressure: two words streamed into a stalled sink
        a_drdy = 1'b0;
        w1 = 24'h000001;
        w2 = 24'h000002;
        for (int i = 0; i < 48; i++) begin
            a_dv  = 1'b1;
            a_din = (i < 24) ? w1[i] : w2[i-24];
            step();
        end
        chk("bp_ready_dropped", a_dr, 1'b0);
        chk("bp_dout_holds_w1", a_dout, 24'h000001);
        chk("bp_partial_in_hold", a_part, 1'b1);
        step();
        chk("bp_still_holding", a_dout, 24'h000001);
        a_dv = 1'b0;
        a_drdy = 1'b1;
        step();
        chk("bp_w2_loaded", a_dout, 24'h000002);
        chk("bp_w2_valid", a_dov, 1'b1);
        chk("bp_ready_returns", a_dr, 1'b1);
        step();
        chk("bp_w2_consumed", a_dov, 1'b0);

        // Final beat of word 2 coincides with consume of word 1
        a_drdy = 1'b0;
        send_a(24'h000003, 24);
        chk("nb_w1_valid", a_dov, 1'b1);
        w2 = 24'h000004;
        for (int i = 0; i < 24; i++) begin
            a_dv  = 1'b1;
            a_din = w2[i];
            if (i == 23) a_drdy = 1'b1;
            step();
        end
        a_dv = 1'b0;
        chk("nb_w2_word", a_dout, 24'h000004);
        chk("nb_w2_valid", a_dov, 1'b1);
        chk("nb_no_hold_ready", a_dr, 1'b1);
        chk("nb_no_hold_partial", a_part, 1'b0);
        step();
        chk("nb_w2_consumed", a_dov, 1'b0);

        // Enable freeze then clear of a partial word
        send_a(24'hFFFFFF, 10);
        en = 1'b0;
        a_dv = 1'b1;
        a_din = 1'b1;
        #1;
        chk("en_low_ready", a_dr, 1'b0);
        step();
        step();
        step();
        chk("en_low_partial_kept", a_part, 1'b1);
        en = 1'b1;
        clr = 1'b1;
        #1;
        chk("clr_ready_high", a_dr, 1'b1);
        step();
        clr = 1'b0;
        a_dv = 1'b0;
        chk("clr_partial", a_part, 1'b0);
        chk("clr_no_word", a_dov, 1'b0);
        send_a(24'h123456, 24);
        chk("after_clr_valid", a_dov, 1'b1);
        chk("after_clr_word", a_dout, 24'h123456);
        step();

        // Reset mid-word
        send_a(24'hFFFFFF, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_partial", a_part, 1'b0);
        chk("rst_mid_no_word", a_dov, 1'b0);
        send_a(24'hC0FFEE, 24);
        chk("after_rst_valid", a_dov, 1'b1);
        chk("after_rst_word", a_dout, 24'hC0FFEE);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
